// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-RAM arbiter.
package mem_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // funct3 encodings understood by the ram
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_B  = 3'b000;  // SB

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Two-way priority picker: data port wins a tie.
// Optional feature macro: ARB_STARVE_GUARD_EN -- after STARVE_LIMIT data
// grants made while fetch was waiting, the next tie goes to fetch.
module arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,           // arbiter may grant this cycle
    input  logic fetch_valid_i,
    input  logic data_valid_i,
    output logic fetch_gnt_o,
    output logic data_gnt_o
);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          force_fetch;

    assign force_fetch = (cnt_q == CW'(STARVE_LIMIT));

    // Grant: data first unless fetch has been starved long enough
    always_comb begin
        fetch_gnt_o = en_i && fetch_valid_i && (!data_valid_i || force_fetch);
        data_gnt_o  = en_i && data_valid_i && !(fetch_valid_i && force_fetch);
    end

    // Starve counter: counts data grants that left fetch waiting, saturating
    always_comb begin
        cnt_d = cnt_q;
        if (fetch_gnt_o)
            cnt_d = '0;
        else if (data_gnt_o && fetch_valid_i && !force_fetch)
            cnt_d = cnt_q + 1'b1;
    end

    // Starve counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    // Strict data priority; clock, reset and the limit have no role here
    logic unused_ok;
    assign unused_ok = ^{clk, rst, 32'(STARVE_LIMIT)};

    assign fetch_gnt_o = en_i && fetch_valid_i && !data_valid_i;
    assign data_gnt_o  = en_i && data_valid_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-ported unified RAM between fetch and LSU.
// Each transaction runs IDLE -> ACCESS -> RESP; RAM pins come straight from
// registers and are non-zero only during ACCESS.
// Optional feature macro: ARB_STARVE_GUARD_EN (see arb_prio).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_funct3,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [31:0]       d_rsp_data,
    output logic [31:0]       ram_address,
    output logic [31:0]       ram_write_data,
    output logic              ram_w_write_enable,
    output logic              ram_b_write_enable,
    output logic              ram_read_enable,
    output logic [2:0]        ram_funct3,
    input  logic [31:0]       ram_read_data
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        rd_en_q, rd_en_d;
    logic        w_en_q, w_en_d;
    logic        b_en_q, b_en_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        gnt_i, gnt_d;

    arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q == IDLE),
        .fetch_valid_i(i_req_valid),
        .data_valid_i (d_req_valid),
        .fetch_gnt_o  (gnt_i),
        .data_gnt_o   (gnt_d)
    );

    // Next state, request latching and response capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        // RAM pin registers fall back to zero outside ACCESS
        addr_d      = '0;
        wdata_d     = '0;
        f3_d        = '0;
        rd_en_d     = 1'b0;
        w_en_d      = 1'b0;
        b_en_d      = 1'b0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                i_req_ready = gnt_i;
                d_req_ready = gnt_d;
                if (gnt_d) begin
                    state_d = ACCESS;
                    owner_d = OWN_D;
                    we_d    = d_req_we;
                    addr_d  = 32'(d_req_addr);
                    wdata_d = d_req_wdata;
                    f3_d    = d_req_funct3;
                    rd_en_d = !d_req_we;
                    // Stores with an unsupported funct3 touch nothing but still ack
                    w_en_d  = d_req_we && (d_req_funct3 == F3_W);
                    b_en_d  = d_req_we && (d_req_funct3 == F3_B);
                end else if (gnt_i) begin
                    state_d = ACCESS;
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = 32'(i_req_addr);
                    f3_d    = F3_W;
                    rd_en_d = 1'b1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (owner_q == OWN_I) i_rdata_d = ram_read_data;
                else                  d_rdata_d = we_q ? 32'h0 : ram_read_data;
            end
            RESP: begin
                if ((owner_q == OWN_I && i_rsp_ready) || (owner_q == OWN_D && d_rsp_ready))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            rd_en_q   <= 1'b0;
            w_en_q    <= 1'b0;
            b_en_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            rd_en_q   <= rd_en_d;
            w_en_q    <= w_en_d;
            b_en_q    <= b_en_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign ram_address        = addr_q;
    assign ram_write_data     = wdata_q;
    assign ram_funct3         = f3_q;
    assign ram_read_enable    = rd_en_q;
    assign ram_w_write_enable = w_en_q;
    assign ram_b_write_enable = b_en_q;

    assign i_rsp_valid = (state_q == RESP) && (owner_q == OWN_I);
    assign d_rsp_valid = (state_q == RESP) && (owner_q == OWN_D);
    assign i_rsp_data  = i_rdata_q;
    assign d_rsp_data  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a byte-array RAM model.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int LIMIT = 4;

    logic        clk, rst, mem_init;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
    logic [2:0]  d_req_funct3;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [31:0] ram_address, ram_write_data, ram_read_data;
    logic        ram_w_write_enable, ram_b_write_enable, ram_read_enable;
    logic [2:0]  ram_funct3;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram_mem [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] wa;

    mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_w_write_enable(ram_w_write_enable), .ram_b_write_enable(ram_b_write_enable),
        .ram_read_enable(ram_read_enable), .ram_funct3(ram_funct3),
        .ram_read_data(ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on the clock edge
    assign wa = {ram_address[7:2], 2'b00};
    always_comb begin
        ram_read_data = '0;
        if (ram_read_enable) begin
            case (ram_funct3)
                F3_W:  ram_read_data = {ram_mem[wa+8'd3], ram_mem[wa+8'd2], ram_mem[wa+8'd1], ram_mem[wa]};
                F3_BU: ram_read_data = {24'h0, ram_mem[ram_address[7:0]]};
                default: ram_read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h0;
        end else begin
            if (ram_w_write_enable) begin
                ram_mem[wa]      <= ram_write_data[7:0];
                ram_mem[wa+8'd1] <= ram_write_data[15:8];
                ram_mem[wa+8'd2] <= ram_write_data[23:16];
                ram_mem[wa+8'd3] <= ram_write_data[31:24];
            end
            if (ram_b_write_enable) ram_mem[ram_address[7:0]] <= ram_write_data[7:0];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference semantics of one transaction on a byte-addressed memory
    task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        int b, w;
        b  = int'(a[7:0]);
        w  = int'({a[7:2], 2'b00});
        rd = '0;
        if (we) begin
            if (f3 == F3_W) for (int i = 0; i < 4; i++) ref_mem[w+i] = wd[8*i +: 8];
            else if (f3 == F3_B) ref_mem[b] = wd[7:0];
        end else begin
            if (f3 == F3_W) for (int i = 0; i < 4; i++) rd[8*i +: 8] = ref_mem[w+i];
            else if (f3 == F3_BU) rd = {24'h0, ref_mem[b]};
        end
    endtask

    // One isolated transaction from an idle arbiter with timing and pin checks
    task automatic txn(input bit is_i, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp,
                       input int ew, input int eb, input int er, input string nm);
        int nw, nb, nr;
        nw = 0; nb = 0; nr = 0;
        @(negedge clk);
        if (is_i) begin
            i_req_valid = 1'b1; i_req_addr = addr; i_rsp_ready = 1'b1;
        end else begin
            d_req_valid = 1'b1; d_req_we = we; d_req_funct3 = f3;
            d_req_addr = addr; d_req_wdata = wdata; d_rsp_ready = 1'b1;
        end
        #1;
        chk({nm, " req_ready"}, 32'(is_i ? i_req_ready : d_req_ready), 32'd1);
        chk({nm, " other_ready"}, 32'(is_i ? d_req_ready : i_req_ready), 32'd0);
        @(negedge clk);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        #1;
        chk({nm, " ram_address"}, ram_address, addr);
        chk({nm, " ram_funct3"}, 32'(ram_funct3), 32'(f3));
        chk({nm, " rsp_early"}, 32'(is_i ? i_rsp_valid : d_rsp_valid), 32'd0);
        nw += int'(ram_w_write_enable); nb += int'(ram_b_write_enable); nr += int'(ram_read_enable);
        @(negedge clk); #1;
        chk({nm, " rsp_valid"}, 32'(is_i ? i_rsp_valid : d_rsp_valid), 32'd1);
        chk({nm, " rsp_data"}, is_i ? i_rsp_data : d_rsp_data, exp);
        chk({nm, " ram_addr_idle"}, ram_address, 32'h0);
        nw += int'(ram_w_write_enable); nb += int'(ram_b_write_enable); nr += int'(ram_read_enable);
        @(negedge clk); #1;
        chk({nm, " rsp_drop"}, 32'(is_i ? i_rsp_valid : d_rsp_valid), 32'd0);
        nw += int'(ram_w_write_enable); nb += int'(ram_b_write_enable); nr += int'(ram_read_enable);
        chk({nm, " w_en_cycles"}, 32'(nw), 32'(ew));
        chk({nm, " b_en_cycles"}, 32'(nb), 32'(eb));
        chk({nm, " rd_en_cycles"}, 32'(nr), 32'(er));
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          ew, eb, er;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int d_rsp_c, i_gnt_c, i_rsp_c, conc, ng;
        logic [31:0] d_got, i_got;
        int gseq[$];
        bit hs_i, hs_d, ip, dp, ipv, dpv;
        logic [31:0] ie, de;
        int ic, dc, op;

        tbl[0]  = '{1'b1, F3_W,   32'h00, 32'hDEADBEEF, 32'h0,        1, 0, 0};
        tbl[1]  = '{1'b0, F3_W,   32'h00, 32'h0,        32'hDEADBEEF, 0, 0, 1};
        tbl[2]  = '{1'b1, F3_B,   32'h23, 32'h000000AB, 32'h0,        0, 1, 0};
        tbl[3]  = '{1'b0, F3_BU,  32'h23, 32'h0,        32'h000000AB, 0, 0, 1};
        tbl[4]  = '{1'b0, F3_W,   32'h20, 32'h0,        32'hAB000000, 0, 0, 1};
        tbl[5]  = '{1'b0, F3_BU,  32'h01, 32'h0,        32'h000000BE, 0, 0, 1};
        tbl[6]  = '{1'b1, 3'b001, 32'h00, 32'h11112222, 32'h0,        0, 0, 0};
        tbl[7]  = '{1'b0, F3_W,   32'h00, 32'h0,        32'hDEADBEEF, 0, 0, 1};
        tbl[8]  = '{1'b0, 3'b001, 32'h00, 32'h0,        32'h0,        0, 0, 1};
        tbl[9]  = '{1'b1, F3_B,   32'h02, 32'hFFFFFF55, 32'h0,        0, 1, 0};
        tbl[10] = '{1'b0, F3_W,   32'h00, 32'h0,        32'hDE55BEEF, 0, 0, 1};

        rst = 1'b1; mem_init = 1'b1;
        i_req_valid = 0; i_req_addr = 0; i_rsp_ready = 0;
        d_req_valid = 0; d_req_we = 0; d_req_funct3 = 0; d_req_addr = 0; d_req_wdata = 0; d_rsp_ready = 0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst i_req_ready", 32'(i_req_ready), 0);
        chk("rst d_req_ready", 32'(d_req_ready), 0);
        chk("rst rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 0);
        chk("rst rsp_data", i_rsp_data | d_rsp_data, 0);
        chk("rst ram_pins", ram_address | ram_write_data | 32'({ram_read_enable, ram_w_write_enable, ram_b_write_enable, ram_funct3}), 0);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;

        for (int k = 0; k < 11; k++)
            txn(1'b0, tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wdata, tbl[k].exp,
                tbl[k].ew, tbl[k].eb, tbl[k].er, $sformatf("vec%0d", k));

        // Fetch only
        txn(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1, 0, 0, "sw10");
        txn(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1, "fetch10");

        // Simultaneous fetch 0x0 and LW 0x20: data first, fetch on the next IDLE
        @(negedge clk);
        i_req_valid = 1; i_req_addr = 32'h0; i_rsp_ready = 1;
        d_req_valid = 1; d_req_we = 0; d_req_funct3 = F3_W; d_req_addr = 32'h20; d_rsp_ready = 1;
        #1;
        chk("sim d_ready", 32'(d_req_ready), 1);
        chk("sim i_ready", 32'(i_req_ready), 0);
        d_rsp_c = -1; i_gnt_c = -1; i_rsp_c = -1; conc = 0; d_got = 0; i_got = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            d_req_valid = 0;
            if (i_gnt_c > 0) i_req_valid = 0;
            #1;
            if (i_rsp_valid && d_rsp_valid) conc++;
            if (d_rsp_valid && d_rsp_c < 0) begin d_rsp_c = c; d_got = d_rsp_data; end
            if (i_rsp_valid && i_rsp_c < 0) begin i_rsp_c = c; i_got = i_rsp_data; end
            if (i_req_valid && i_req_ready && i_gnt_c < 0) i_gnt_c = c;
        end
        chk("sim d_rsp_cycle", 32'(d_rsp_c), 2);
        chk("sim d_rsp_data", d_got, 32'hAB000000);
        chk("sim i_gnt_cycle", 32'(i_gnt_c), 3);
        chk("sim i_rsp_cycle", 32'(i_rsp_c), 5);
        chk("sim i_rsp_data", i_got, 32'hDE55BEEF);
        chk("sim concurrent", 32'(conc), 0);

        // Response backpressure with fetch waiting
        @(negedge clk);
        d_req_valid = 1; d_req_we = 0; d_req_funct3 = F3_W; d_req_addr = 32'h0; d_rsp_ready = 0;
        #1 chk("bp d_ready", 32'(d_req_ready), 1);
        @(negedge clk);
        d_req_valid = 0; i_req_valid = 1; i_req_addr = 32'h10; i_rsp_ready = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("bp d_rsp_valid", 32'(d_rsp_valid), 1);
            chk("bp d_rsp_data", d_rsp_data, 32'hDE55BEEF);
            chk("bp i_ready", 32'(i_req_ready), 0);
        end
        d_rsp_ready = 1;
        @(negedge clk); #1;
        chk("bp d_rsp_drop", 32'(d_rsp_valid), 0);
        chk("bp d_data_hold", d_rsp_data, 32'hDE55BEEF);
        chk("bp i_ready_after", 32'(i_req_ready), 1);
        @(negedge clk);
        i_req_valid = 0;
        @(negedge clk); #1;
        chk("bp i_rsp_valid", 32'(i_rsp_valid), 1);
        chk("bp i_rsp_data", i_rsp_data, 32'hDEADBEEF);
        @(negedge clk);

        // Reset during the ACCESS of a store
        txn(1'b0, 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 1, 0, 0, "sw40_old");
        @(negedge clk);
        d_req_valid = 1; d_req_we = 1; d_req_funct3 = F3_W; d_req_addr = 32'h40;
        d_req_wdata = 32'h12345678; d_rsp_ready = 1;
        #1 chk("rstacc d_ready", 32'(d_req_ready), 1);
        @(negedge clk);
        d_req_valid = 0;
        #1 chk("rstacc w_en_before", 32'(ram_w_write_enable), 1);
        rst = 1'b1;
        #1;
        chk("rstacc w_en", 32'(ram_w_write_enable), 0);
        chk("rstacc ram_pins", ram_address | ram_write_data, 0);
        chk("rstacc rsp", 32'({d_rsp_valid, i_rsp_valid}), 0);
        chk("rstacc d_rsp_data", d_rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstacc rsp_after", 32'(d_rsp_valid), 0);
        txn(1'b0, 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0, 1, "lw40_after");

        // Starvation behaviour under continuous contention
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        i_req_valid = 1; i_req_addr = 32'h10; i_rsp_ready = 1;
        d_req_valid = 1; d_req_we = 0; d_req_funct3 = F3_W; d_req_addr = 32'h0; d_rsp_ready = 1;
        ng = 0;
        for (int c = 0; c < 80 && ng < 15; c++) begin
            #1;
            if (d_req_ready) begin gseq.push_back(0); ng++; end
            else if (i_req_ready) begin gseq.push_back(1); ng++; end
            @(negedge clk);
        end
        i_req_valid = 0; d_req_valid = 0;
        chk("starve grant_count", 32'(ng), 15);
        for (int k = 0; k < gseq.size(); k++) begin
`ifdef ARB_STARVE_GUARD_EN
            chk($sformatf("starve grant%0d", k), 32'(gseq[k]), 32'((k % (LIMIT + 1)) == LIMIT));
`else
            chk($sformatf("starve grant%0d", k), 32'(gseq[k]), 0);
`endif
        end
        repeat (4) @(negedge clk);

        // Randomized traffic against the reference model
        ref_mem = ram_mem;
        hs_i = 0; hs_d = 0; ip = 0; dp = 0; ipv = 0; dpv = 0; ie = 0; de = 0; ic = 0; dc = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (c < 660) begin
                if (hs_i || !i_req_valid) begin
                    i_req_valid = ($urandom % 3) == 0;
                    i_req_addr  = {24'h0, 8'($urandom) & 8'hFC};
                end
                if (hs_d || !d_req_valid) begin
                    op = int'($urandom_range(0, 3));
                    d_req_valid  = ($urandom % 2) == 0;
                    d_req_we     = (op < 2);
                    d_req_funct3 = (op == 0 || op == 2) ? F3_W : (op == 1 ? F3_B : F3_BU);
                    d_req_addr   = {24'h0, 8'($urandom) & ((op == 0 || op == 2) ? 8'hFC : 8'hFF)};
                    d_req_wdata  = $urandom;
                end
                i_rsp_ready = ($urandom % 4) != 0;
                d_rsp_ready = ($urandom % 4) != 0;
            end else begin
                if (hs_i) i_req_valid = 0;
                if (hs_d) d_req_valid = 0;
                if (!i_req_valid && !d_req_valid) begin i_rsp_ready = 1; d_rsp_ready = 1; end
            end
            #1;
            hs_i = i_req_valid && i_req_ready;
            hs_d = d_req_valid && d_req_ready;
            if (i_req_ready && d_req_ready) chk("rnd one_ready", 1, 0);
            if ((hs_i || hs_d) && (ip || dp)) chk("rnd accept_busy", 1, 0);
`ifndef ARB_STARVE_GUARD_EN
            if (i_req_valid && d_req_valid && (hs_i || hs_d)) chk("rnd prio", 32'(hs_d), 1);
`endif
            if (i_rsp_valid) begin
                if (!ip) chk("rnd i_rsp_spurious", 1, 0);
                else begin
                    if (!ipv) chk("rnd i_latency", 32'(c - ic), 2);
                    if (i_rsp_ready) begin chk("rnd i_data", i_rsp_data, ie); ip = 0; end
                end
            end else if (ip && (c - ic) >= 2) begin
                chk("rnd i_rsp_missing", 0, 1); ip = 0;
            end
            if (d_rsp_valid) begin
                if (!dp) chk("rnd d_rsp_spurious", 1, 0);
                else begin
                    if (!dpv) chk("rnd d_latency", 32'(c - dc), 2);
                    if (d_rsp_ready) begin chk("rnd d_data", d_rsp_data, de); dp = 0; end
                end
            end else if (dp && (c - dc) >= 2) begin
                chk("rnd d_rsp_missing", 0, 1); dp = 0;
            end
            ipv = i_rsp_valid && !i_rsp_ready;
            dpv = d_rsp_valid && !d_rsp_ready;
            if (hs_i) begin ref_op(1'b0, F3_W, i_req_addr, 32'h0, ie); ip = 1; ic = c; end
            if (hs_d) begin ref_op(d_req_we, d_req_funct3, d_req_addr, d_req_wdata, de); dp = 1; dc = c; end
        end
        chk("rnd drained", 32'({ip, dp}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-ported, DPI-backed unified RAM between the instruction-fetch unit and the load/store unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block sequences every transaction as IDLE -> ACCESS -> RESP and drives the RAM's address, data, enable and funct3 pins from registers. It sits between the core front-end/LSU and the ram instance in the top-level.

Parameters:
- ADDR_W, 32, address width on all ports.
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced (only used with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_W  fetch address; word read only.
- i_rsp_valid  out  1  fetch data valid.
- i_rsp_ready  in  1  fetch consumer ready.
- i_rsp_data  out  32  fetched word.
- d_req_valid  in  1  LSU request valid.
- d_req_ready  out  1  LSU request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_funct3  in  3  010 = LW/SW, 100 = LBU, 000 = SB.
- d_req_addr  in  ADDR_W  byte address.
- d_req_wdata  in  32  store data.
- d_rsp_valid  out  1  LSU response valid (load data or store ack).
- d_rsp_ready  in  1  LSU consumer ready.
- d_rsp_data  out  32  load data; 0 for stores.
- ram_address  out  32  to ram address.
- ram_write_data  out  32  to ram write_data.
- ram_w_write_enable  out  1  to ram w_write_enable.
- ram_b_write_enable  out  1  to ram b_write_enable.
- ram_read_enable  out  1  to ram read_enable.
- ram_funct3  out  3  to ram funct3.
- ram_read_data  in  32  from ram read_data (combinational read).

Behaviour:
- Reset values: all outputs 0; state = IDLE; owner = none; starve counter = 0.
- FSM states:
  - IDLE: arbitrate among valid requesters. The winner's req_ready is 1 combinationally in this cycle; the loser's is 0. Latch owner, addr, we, funct3 and wdata. Fetch latches funct3 = 010 and we = 0. Go to ACCESS. With no request, stay in IDLE.
  - ACCESS (exactly 1 cycle): RAM pins are driven only from latched registers and are zero in every other state.
    - Load: ram_read_enable = 1. ram_read_data is captured into the response register at the end of the cycle.
    - Store, funct3 010: ram_w_write_enable = 1.
    - Store, funct3 000: ram_b_write_enable = 1.
    - Store, any other funct3: no enable; the ack is still returned.
    - Load, funct3 other than 010 or 100: ram_read_enable = 1; ram returns 0.
    - Go to RESP.
  - RESP: the owner's rsp_valid = 1 and rsp_data stays stable until rsp_ready. On the handshake, return to IDLE. No new request is accepted in RESP.
- Latency and throughput: request handshake to rsp_valid takes 2 cycles. Minimum 3 cycles per transaction.
- Priority: the data port wins a simultaneous request (strict).
- Only one req_ready is ever high, and only in IDLE.
- The response data register holds its value after the handshake until the next capture. rsp_valid drops the cycle after the handshake.
- Reset mid-operation: asynchronous return to IDLE.
  - A store in ACCESS during reset is dropped; no enable reaches the ram.
  - A pending response is discarded.
- Addresses pass through unmodified. Byte-lane selection is done by the ram from address[1:0].

Optional Feature:
- ARB_STARVE_GUARD_EN defined: a saturating counter increments on each data grant made while i_req_valid = 1. It clears on any fetch grant. When the counter reaches STARVE_LIMIT, the next simultaneous request is granted to fetch.
- Not defined: strict data priority; the counter logic and STARVE_LIMIT are unused.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP) and the owner enum (OWN_I, OWN_D);
  - funct3 constants F3_W = 3'b010, F3_BU = 3'b100, F3_B = 3'b000.
- One natural sub-module: arb_prio, the 2-way priority picker containing the optional starve counter.
- The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Fetch only: i_req addr 0x10, ram word 0xDEADBEEF -> i_req_ready same cycle, i_rsp_valid 2 cycles later with 0xDEADBEEF, ram_read_enable high for exactly 1 cycle.
- Simultaneous fetch 0x0 and LW 0x20 -> data granted first, fetch granted on the next IDLE; responses are never concurrent.
- SB addr 0x23, wdata 0xAB, then LBU 0x23 -> ram_b_write_enable pulses 1 cycle; d_rsp_data of the load = 0x000000AB.
- Response backpressure: hold d_rsp_ready = 0 for 5 cycles -> d_rsp_valid and data stable, i_req_ready stays 0 throughout.
- Reset asserted during the ACCESS of SW 0x40 = 0x12345678 -> no write enable, outputs 0 immediately; a subsequent LW 0x40 returns the old value.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4: continuous d_req_valid plus i_req_valid -> 4 data grants, then 1 fetch grant, repeating. Without the macro -> fetch is never granted.
